pid_integrator: RTL and testbench

Signed error integrator for the PID datapath: sits directly downstream of the 16-bit adder that forms the error term (setpoint + negated measurement). It accepts one error sample per handshake, adds it to a running accumulator, and clamps the result. It presents the new integral on a registered valid/ready output for the I-gain multiplier stage.

---
 rtl/pid_pkg.sv | 13 +
 rtl/pid_sat_add.sv | 39 +++
 rtl/pid_integrator.sv | 92 +++++++++
 tb/tb_pid_integrator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID datapath: FSM state encoding and default widths/limits.
package pid_pkg;

  localparam int PID_W           = 16;
  localparam int PID_INTEG_LIMIT = 32767;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } pid_state_t;

endpackage

// File: rtl/pid_sat_add.sv
// Combinational signed add of accumulator and error, with optional symmetric clamp.
// Clamp is built only when PID_INTEG_SAT_EN is defined; otherwise the sum wraps.
module pid_sat_add #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 32767
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

`ifdef PID_INTEG_SAT_EN
  localparam logic signed [WIDTH:0] POS_LIM = (WIDTH+1)'(LIMIT);
  localparam logic signed [WIDTH:0] NEG_LIM = -POS_LIM;

  logic signed [WIDTH:0] sum;

  // One extra bit keeps the true sum so both overflow directions are visible.
  assign sum = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});

  always_comb begin
    result = sum[WIDTH-1:0];
    sat    = 1'b0;
    if (sum > POS_LIM) begin
      result = POS_LIM[WIDTH-1:0];
      sat    = 1'b1;
    end else if (sum < NEG_LIM) begin
      result = NEG_LIM[WIDTH-1:0];
      sat    = 1'b1;
    end
  end
`else
  // Without the clamp the carry bit is irrelevant: the low WIDTH bits are the wrapped sum.
  assign result = a + b;
  assign sat    = 1'b0;
`endif

endmodule

// File: rtl/pid_integrator.sv
// Signed error integrator: accepts one error per handshake, accumulates, clamps and
// presents the result on a registered valid/ready output. Clamp enabled by PID_INTEG_SAT_EN.
module pid_integrator
  import pid_pkg::*;
#(
  parameter int WIDTH = PID_W,
  parameter int LIMIT = PID_INTEG_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] integ,
  output logic             sat
);

  pid_state_t       state, next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] sum_res;
  logic             sum_sat;
  logic             accept;

  pid_sat_add #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) u_sat_add (
    .a      (acc),
    .b      (err_q),
    .result (sum_res),
    .sat    (sum_sat)
  );

  assign in_ready = (state == IDLE) && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = ADD;
      ADD:     next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Clear overrides every datapath update, including a result being formed in ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      integ     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      err_q     <= '0;
    end else if (clear) begin
      acc       <= '0;
      integ     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) err_q <= err;
        end
        ADD: begin
          acc       <= sum_res;
          integ     <= sum_res;
          sat       <= sum_sat;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_integrator.sv
// Directed bench for pid_integrator with a transaction-level integral model and a
// per-cycle compare of integ/sat. Clamp scenario runs when PID_INTEG_SAT_EN is defined.
module tb_pid_integrator;

`ifdef PID_INTEG_SAT_EN
  localparam int LIM = 1000;
`else
  localparam int LIM = 32767;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] err = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] integ;
  logic        sat;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] exp_integ = '0;
  logic               exp_sat = 1'b0;
  logic               chk_en = 1'b0;

  pid_integrator #(
    .WIDTH (16),
    .LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .integ     (integ),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: the integral is the running sum of accepted errors, clamped or wrapped.
  task automatic model_add(input logic signed [15:0] e);
    int s;
    s = int'(exp_integ) + int'(e);
`ifdef PID_INTEG_SAT_EN
    if (s > LIM) begin
      exp_integ = 16'(LIM);  exp_sat = 1'b1;
    end else if (s < -LIM) begin
      exp_integ = 16'(-LIM); exp_sat = 1'b1;
    end else begin
      exp_integ = 16'(s);    exp_sat = 1'b0;
    end
`else
    exp_integ = 16'(s);
    exp_sat   = 1'b0;
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_integ", int'($signed(integ)), int'(exp_integ));
      chk("cyc_sat", int'(sat), int'(exp_sat));
    end
  end

  // One full transaction: offer, accept, result one edge later, then consume after stall cycles.
  task automatic send(input logic signed [15:0] e, input int stall);
    int n;
    @(negedge clk);
    err = e;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("add_in_ready", int'(in_ready), 0);
    chk("add_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 model_add(e);
    chk("res_out_valid", int'(out_valid), 1);
    chk("res_in_ready", int'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("consumed_out_valid", int'(out_valid), 0);
    chk("consumed_in_ready", int'(in_ready), 1);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1 chk("clear_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    exp_integ = '0;
    exp_sat   = 1'b0;
    chk("clear_integ", int'($signed(integ)), 0);
    chk("clear_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_integ", int'($signed(integ)), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk_en = 1'b1;
    send(16'sd5, 0);
    chk("first_integ", int'($signed(integ)), 5);

    // Accumulate with backpressure on the second result
    do_clear();
    send(16'sd100, 0);
    chk("acc_100", int'($signed(integ)), 100);
    send(16'sd200, 3);
    chk("acc_300", int'($signed(integ)), 300);
    send(-16'sd50, 0);
    chk("acc_250", int'($signed(integ)), 250);

    // Clear competing with an offered sample
    do_clear();
    send(16'sd400, 0);
    chk("acc_400", int'($signed(integ)), 400);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    err = 16'sd77;
    #1 chk("clr_pri_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    exp_integ = '0;
    exp_sat = 1'b0;
    chk("clr_pri_integ", int'($signed(integ)), 0);
    chk("clr_pri_out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("clr_pri_no_accept", int'(out_valid), 0);
    chk("clr_pri_idle", int'(in_ready), 1);

    // Clear while a sample sits in ADD: result discarded
    send(16'sd20, 0);
    @(negedge clk);
    err = 16'sd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_integ = '0;
    exp_sat = 1'b0;
    chk("clr_add_integ", int'($signed(integ)), 0);
    chk("clr_add_out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("clr_add_still_idle", int'(out_valid), 0);

`ifdef PID_INTEG_SAT_EN
    // Clamp at +/-1000
    send(16'sd600, 0);
    send(16'sd600, 0);
    chk("clamp_pos", int'($signed(integ)), 1000);
    chk("clamp_pos_sat", int'(sat), 1);
    send(-16'sd3000, 0);
    chk("clamp_neg", int'($signed(integ)), -1000);
    chk("clamp_neg_sat", int'(sat), 1);
    send(16'sd10, 0);
    chk("unclamp", int'($signed(integ)), -990);
    chk("unclamp_sat", int'(sat), 0);
`else
    // Two's complement wrap
    send(16'sd32767, 0);
    chk("wrap_max", int'($signed(integ)), 32767);
    send(16'sd1, 0);
    chk("wrap_min", int'($signed(integ)), -32768);
    chk("wrap_sat", int'(sat), 0);
`endif

    // Asynchronous reset while holding a result
    do_clear();
    @(negedge clk);
    err = 16'sd77;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 model_add(16'sd77);
    @(negedge clk);
    chk("hold_integ", int'($signed(integ)), 77);
    chk("hold_out_valid", int'(out_valid), 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_integ", int'($signed(integ)), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_sat", int'(sat), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    exp_integ = '0;
    exp_sat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    send(16'sd3, 0);
    chk("post_rst_integ", int'($signed(integ)), 3);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
